fifo_burst_reader: RTL and testbench

- Read-side consumer for the team's asyncfifo; lives entirely in the read clock domain.
- On a start pulse, pops exactly `burst_len` words from the FIFO read port (RD/EN/DataOut/EMPTY).
- Presents the words downstream on a valid/ready stream with a 2-entry skid buffer, so backpressure never loses a word.
- Reports busy/done and a per-burst word count.

---
 rtl/fifo_burst_reader.sv | 111 +++++++++++
 tb/tb_fifo_burst_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a fixed-length burst from an asyncfifo read port and streams it out through a 2-entry skid buffer.
// Ports:
//   rd_clk, rst            read-domain clock, synchronous active-high reset
//   start, burst_len       begin a burst of burst_len words (accepted only when idle)
//   fifo_empty, fifo_data  asyncfifo EMPTY / DataOut
//   fifo_rd, fifo_en       asyncfifo RD / EN
//   m_data, m_valid,
//   m_ready, m_last        downstream valid/ready stream, m_last marks the final word
//   busy, done             burst in progress / one-cycle completion pulse
//   words_read             words accepted downstream in the current or last burst
//   seq_err                sticky low-16-bit sequence error
// Optional: define FIFO_BURST_READER_SEQCHK_EN to build the sequence checker; otherwise seq_err is 0.
module fifo_burst_reader #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              rd_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              fifo_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_read,
    output logic              seq_err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] remaining, len;
    logic [DATA_W-1:0] buf0, buf1;
    logic [1:0] occ;
    logic inflight, go, pop;
    assign go      = (state == IDLE) && start;
    assign busy    = (state == RUN) || (state == DRAIN);
    assign done    = (state == DONE);
    assign fifo_en = busy;
    assign m_valid = (occ != 2'd0);
    assign m_data  = buf0;
    assign pop     = m_valid && m_ready;
    // head word number is words_read+1; wraps consistently with burst_len
    assign m_last  = m_valid && (CNT_W'(words_read + 1'b1) == len);
    // a captured word always has a free slot because occupancy+inflight never exceeds 2
    assign fifo_rd = busy && (state == RUN) && !fifo_empty && (remaining != '0) &&
                     ((occ + {1'b0, inflight}) < 2'd2);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (burst_len == '0) ? DONE : RUN;
            RUN:     if (fifo_rd && remaining == CNT_W'(1)) state_nx = DRAIN;
            DRAIN:   if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop))) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            len        <= '0;
            words_read <= '0;
            inflight   <= 1'b0;
            occ        <= 2'd0;
            buf0       <= '0;
            buf1       <= '0;
        end else begin
            state    <= state_nx;
            inflight <= fifo_rd;
            if (go) begin
                remaining  <= burst_len;
                len        <= burst_len;
                words_read <= '0;
            end else begin
                if (fifo_rd) remaining <= remaining - 1'b1;
                if (pop) words_read <= words_read + 1'b1;
            end
            if (inflight && !pop) begin
                if (occ == 2'd0) buf0 <= fifo_data;
                else buf1 <= fifo_data;
            end else if (!inflight && pop) begin
                buf0 <= buf1;
            end else if (inflight && pop) begin
                buf0 <= (occ == 2'd2) ? buf1 : fifo_data;
                buf1 <= fifo_data;
            end
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end
`ifdef FIFO_BURST_READER_SEQCHK_EN
    logic [15:0] expected;
    // first word of a burst seeds the sequence; later words must follow it by +1
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            seq_err  <= 1'b0;
            expected <= '0;
        end else if (go) begin
            seq_err <= 1'b0;
        end else if (pop) begin
            if (words_read != '0 && m_data[15:0] != expected) seq_err <= 1'b1;
            expected <= ((words_read == '0) ? m_data[15:0] : expected) + 16'd1;
        end
    end
`else
    assign seq_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: scoreboard bench for fifo_burst_reader with a queue-based asyncfifo read-port model.
module tb_fifo_burst_reader;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    logic rd_clk = 1'b0, rst = 1'b1, start = 1'b0, fifo_empty = 1'b1, m_ready = 1'b0;
    logic [CNT_W-1:0] burst_len = '0;
    logic [DATA_W-1:0] fifo_data = '0;
    logic fifo_rd, fifo_en, m_valid, m_last, busy, done, seq_err;
    logic [CNT_W-1:0] words_read;
    logic [DATA_W-1:0] m_data;
    always #5 rd_clk = ~rd_clk;
    fifo_burst_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .rd_clk(rd_clk), .rst(rst), .start(start), .burst_len(burst_len),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd), .fifo_en(fifo_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done), .words_read(words_read), .seq_err(seq_err)
    );
    typedef struct {
        int len;
        int preload;
        int mode;
        int exp_words;
        int exp_left;
    } vec_t;
    int checks = 0, passes = 0;
    logic [DATA_W-1:0] fq[$];
    logic [DATA_W-1:0] exp_q[$];
    int blen = 0, acc = 0, issued = 0, done_cnt = 0, cyc = 0, rdy_mode = 0;
    bit busy_m = 0, last_acc = 0, zero_pend = 0, stall = 0, pop_now = 0;
    logic [DATA_W-1:0] stall_data = '0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask
    // Transaction-level scoreboard: every accepted word must be the next word the bench queued
    // for this burst, reads may only be outstanding while fewer than 2 words are unaccepted,
    // and done must follow the final accept by exactly one cycle.
    task automatic monitor();
        if (fifo_rd) begin
            chk("rd_while_empty", 64'(fifo_empty), 64'd0);
            chk("rd_budget", 64'((issued - acc) < 2 && issued < blen), 64'd1);
        end
        chk("busy", 64'(busy), 64'(busy_m));
        chk("fifo_en", 64'(fifo_en), 64'(busy_m));
        chk("done", 64'(done), 64'(last_acc || zero_pend));
        if (done) done_cnt++;
        chk("words_read", 64'(words_read), 64'(acc));
        if (stall) chk("hold", 64'({m_valid, m_data}), 64'({1'b1, stall_data}));
        last_acc = 0;
        zero_pend = 0;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL extra_word: got %0h expected no word", m_data);
            end else begin
                chk("data", 64'(m_data), 64'(exp_q.pop_front()));
                chk("m_last", 64'(m_last), 64'(acc + 1 == blen));
            end
            acc++;
            if (acc == blen) begin
                last_acc = 1;
                busy_m = 0;
            end
        end
        if (pop_now) issued++;
        stall = m_valid && !m_ready;
        stall_data = m_data;
    endtask
    task automatic tick();
        @(negedge rd_clk);
        pop_now = fifo_rd && !fifo_empty;
        if (!rst) monitor();
        @(posedge rd_clk);
        #1;
        if (pop_now) fifo_data = fq.pop_front();
        fifo_empty = (fq.size() == 0);
        cyc++;
        m_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 4 == 0) : 1'($urandom_range(0, 1));
    endtask
    task automatic push(input logic [DATA_W-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask
    task automatic clear_fifo();
        fq.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
    endtask
    task automatic start_burst(input int l);
        burst_len = CNT_W'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
        blen = l;
        acc = 0;
        issued = 0;
        busy_m = (l != 0);
        zero_pend = (l == 0);
    endtask
    task automatic run_until_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        if (done_cnt == d0) begin
            checks++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask
    task automatic end_checks(input int words, input int left);
        tick();
        tick();
        chk("final_words_read", 64'(words_read), 64'(words));
        chk("reads_issued", 64'(issued), 64'(blen));
        chk("fifo_left", 64'(fq.size()), 64'(left));
        chk("words_outstanding", 64'(exp_q.size()), 64'd0);
    endtask
    vec_t vecs[6];
    initial begin
        vecs[0] = '{len: 8, preload: 8,  mode: 0, exp_words: 8, exp_left: 0};
        vecs[1] = '{len: 8, preload: 8,  mode: 1, exp_words: 8, exp_left: 0};
        vecs[2] = '{len: 0, preload: 2,  mode: 0, exp_words: 0, exp_left: 2};
        vecs[3] = '{len: 1, preload: 3,  mode: 0, exp_words: 1, exp_left: 2};
        vecs[4] = '{len: 5, preload: 10, mode: 2, exp_words: 5, exp_left: 5};
        vecs[5] = '{len: 3, preload: 3,  mode: 1, exp_words: 3, exp_left: 0};
        tick();
        tick();
        chk("rst_fifo_rd", 64'(fifo_rd), 64'd0);
        chk("rst_fifo_en", 64'(fifo_en), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_words_read", 64'(words_read), 64'd0);
        chk("rst_seq_err", 64'(seq_err), 64'd0);
        rst = 1'b0;
        tick();
        foreach (vecs[v]) begin
            clear_fifo();
            rdy_mode = vecs[v].mode;
            for (int i = 0; i < vecs[v].preload; i++) begin
                push(32'h1111_0001 + 32'(i));
                if (i < vecs[v].len) exp_q.push_back(32'h1111_0001 + 32'(i));
            end
            start_burst(vecs[v].len);
            run_until_done(200);
            end_checks(vecs[v].exp_words, vecs[v].exp_left);
        end
        // empty stall: 2 words ready, 2 more arrive 100 ns later
        clear_fifo();
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h3333_0001 + 32'(i));
        push(32'h3333_0001);
        push(32'h3333_0002);
        start_burst(4);
        for (int i = 0; i < 10; i++) tick();
        chk("stall_busy", 64'(busy), 64'd1);
        chk("stall_acc", 64'(acc), 64'd2);
        push(32'h3333_0003);
        push(32'h3333_0004);
        begin
            int d0;
            d0 = done_cnt;
            run_until_done(100);
            end_checks(4, 0);
            chk("stall_done_once", 64'(done_cnt - d0), 64'd1);
        end
        // start during an active burst is ignored
        clear_fifo();
        for (int i = 0; i < 6; i++) begin
            push(32'h4444_0001 + 32'(i));
            exp_q.push_back(32'h4444_0001 + 32'(i));
        end
        start_burst(6);
        tick();
        tick();
        burst_len = CNT_W'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_done(100);
        end_checks(6, 0);
        // reset mid-burst after 3 of 8 words, then a fresh 5-word burst
        clear_fifo();
        for (int i = 0; i < 3; i++) begin
            push(32'h2222_0001 + 32'(i));
            exp_q.push_back(32'h2222_0001 + 32'(i));
        end
        start_burst(8);
        for (int i = 0; i < 50 && acc < 3; i++) tick();
        chk("pre_reset_acc", 64'(acc), 64'd3);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_words_read", 64'(words_read), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        blen = 0;
        acc = 0;
        issued = 0;
        busy_m = 0;
        last_acc = 0;
        stall = 0;
        exp_q.delete();
        tick();
        tick();
        for (int i = 3; i < 8; i++) begin
            push(32'h2222_0001 + 32'(i));
            exp_q.push_back(32'h2222_0001 + 32'(i));
        end
        start_burst(5);
        run_until_done(100);
        end_checks(5, 0);
        // sequence checker: 1, 2, 4
        clear_fifo();
        push(32'h1111_0001);
        push(32'h1111_0002);
        push(32'h1111_0004);
        exp_q.push_back(32'h1111_0001);
        exp_q.push_back(32'h1111_0002);
        exp_q.push_back(32'h1111_0004);
        start_burst(3);
        run_until_done(100);
        end_checks(3, 0);
`ifdef FIFO_BURST_READER_SEQCHK_EN
        chk("seq_err_set", 64'(seq_err), 64'd1);
        tick();
        chk("seq_err_sticky", 64'(seq_err), 64'd1);
        start_burst(0);
        chk("seq_err_cleared", 64'(seq_err), 64'd0);
`else
        chk("seq_err_off", 64'(seq_err), 64'd0);
        start_burst(0);
        chk("seq_err_off_after_start", 64'(seq_err), 64'd0);
`endif
        tick();
        tick();
        // randomized bursts with random backpressure and late-arriving FIFO words
        rdy_mode = 2;
        for (int r = 0; r < 25; r++) begin
            int l, pre, d0;
            logic [DATA_W-1:0] pend[$];
            clear_fifo();
            l = $urandom_range(1, 12);
            pre = $urandom_range(0, l);
            for (int i = 0; i < l; i++) begin
                logic [DATA_W-1:0] w;
                w = $urandom;
                exp_q.push_back(w);
                if (i < pre) push(w);
                else pend.push_back(w);
            end
            start_burst(l);
            d0 = done_cnt;
            for (int i = 0; i < 400 && done_cnt == d0; i++) begin
                if (pend.size() > 0 && $urandom_range(0, 2) == 0) push(pend.pop_front());
                tick();
            end
            if (done_cnt == d0) begin
                checks++;
                $display("FAIL rand_timeout: got no done expected done for burst %0d", r);
            end
            end_checks(l, 0);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
